// File: rtl/gate3_driver.sv
// Hazard-button debouncer and blink generator driving a downstream Gate3 cell.
// Define GATE3_DRIVER_SYNC_EN to add a two-flop synchronizer on HazardButton.
module gate3_driver #(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int BLINK_HALF_CYCLES = 12500000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic HazardButton,
  output logic All,
  output logic Blink,
  output logic BlinkTick
);

  localparam int DebW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BlinkW = $clog2(BLINK_HALF_CYCLES);
  localparam logic [DebW-1:0]   DebLast   = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_HALF_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHECK,
    PRESSED,
    RELEASE_CHECK
  } state_t;

  state_t            state, stateNext;
  logic [DebW-1:0]   debCnt, debCntNext;
  logic [BlinkW-1:0] blinkCnt;
  logic              btnSample;
  logic              pressDone;
  logic              allRise;

`ifdef GATE3_DRIVER_SYNC_EN
  logic syncA, syncB;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      syncA <= 1'b0;
      syncB <= 1'b0;
    end else begin
      syncA <= HazardButton;
      syncB <= syncA;
    end
  end

  assign btnSample = syncB;
`else
  assign btnSample = HazardButton;
`endif

  // Counter holds the number of consecutive samples at the candidate level;
  // the DEBOUNCE_CYCLES-th one completes the transition without storing D.
  always_comb begin
    stateNext  = state;
    debCntNext = debCnt;
    pressDone  = 1'b0;
    case (state)
      RELEASED: begin
        if (btnSample) begin
          stateNext  = PRESS_CHECK;
          debCntNext = DebW'(1);
        end
      end
      PRESS_CHECK: begin
        if (!btnSample) begin
          stateNext  = RELEASED;
          debCntNext = '0;
        end else if (debCnt == DebLast) begin
          stateNext  = PRESSED;
          debCntNext = '0;
          pressDone  = 1'b1;
        end else begin
          debCntNext = debCnt + DebW'(1);
        end
      end
      PRESSED: begin
        if (!btnSample) begin
          stateNext  = RELEASE_CHECK;
          debCntNext = DebW'(1);
        end
      end
      RELEASE_CHECK: begin
        if (btnSample) begin
          stateNext  = PRESSED;
          debCntNext = '0;
        end else if (debCnt == DebLast) begin
          stateNext  = RELEASED;
          debCntNext = '0;
        end else begin
          debCntNext = debCnt + DebW'(1);
        end
      end
      default: begin
        stateNext  = RELEASED;
        debCntNext = '0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= RELEASED;
      debCnt <= '0;
    end else begin
      state  <= stateNext;
      debCnt <= debCntNext;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      All <= 1'b0;
    end else if (pressDone) begin
      All <= ~All;
    end
  end

  // Entering hazard mode restarts the blink phase; it outranks terminal count.
  assign allRise = pressDone & ~All;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      blinkCnt  <= '0;
      Blink     <= 1'b0;
      BlinkTick <= 1'b0;
    end else if (allRise) begin
      blinkCnt  <= '0;
      Blink     <= 1'b1;
      BlinkTick <= 1'b1;
    end else if (blinkCnt == BlinkLast) begin
      blinkCnt  <= '0;
      Blink     <= ~Blink;
      BlinkTick <= 1'b1;
    end else begin
      blinkCnt  <= blinkCnt + BlinkW'(1);
      BlinkTick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gate3_driver.sv
// Self-checking bench for gate3_driver with a run-length / phase-anchor reference model.
module tb_gate3_driver;

  localparam int D = 4;
  localparam int H = 5;
`ifdef GATE3_DRIVER_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic HazardButton = 1'b0;
  logic All, Blink, BlinkTick;

  int checks = 0;
  int errors = 0;

  // Reference model state: accepted level, run length of opposite samples,
  // and the edge from which the blink phase is measured.
  int edgeN = 0;
  int anchor = 0;
  bit anchorVal = 1'b0;
  bit accLevel = 1'b0;
  int run = 0;
  bit allM = 1'b0;
  bit blinkM = 1'b0;
  bit tickM = 1'b0;
  bit s1 = 1'b0;
  bit s2 = 1'b0;

  gate3_driver #(
    .DEBOUNCE_CYCLES  (D),
    .BLINK_HALF_CYCLES(H)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .HazardButton(HazardButton),
    .All         (All),
    .Blink       (Blink),
    .BlinkTick   (BlinkTick)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL timeout edge=%0d", edgeN);
    $fatal(1, "timeout");
  end

  task automatic step(input bit btn, input bit rst);
    bit smp;
    bit rise;
    int d;
    HazardButton = btn;
    Reset = rst;
    @(posedge Clock);
    edgeN++;
    if (L == 2) begin
      smp = s2;
      s2 = s1;
      s1 = btn;
    end else begin
      smp = btn;
    end
    rise = 1'b0;
    if (rst) begin
      s1 = 1'b0;
      s2 = 1'b0;
      accLevel = 1'b0;
      run = 0;
      allM = 1'b0;
      anchor = edgeN;
      anchorVal = 1'b0;
      blinkM = 1'b0;
      tickM = 1'b0;
    end else begin
      if (smp != accLevel) begin
        run++;
        if (run == D) begin
          accLevel = smp;
          run = 0;
          if (smp) begin
            allM = !allM;
            rise = allM;
          end
        end
      end else begin
        run = 0;
      end
      if (rise) begin
        anchor = edgeN;
        anchorVal = 1'b1;
        blinkM = 1'b1;
        tickM = 1'b1;
      end else begin
        d = edgeN - anchor;
        blinkM = anchorVal ^ bit'((d / H) % 2);
        tickM = (d > 0) && (d % H == 0);
      end
    end
    #1;
    if (All !== allM) begin
      errors++;
      $display("FAIL model_all edge=%0d got=%b exp=%b", edgeN, All, allM);
    end
    checks++;
    if (Blink !== blinkM) begin
      errors++;
      $display("FAIL model_blink edge=%0d got=%b exp=%b", edgeN, Blink, blinkM);
    end
    checks++;
    if (BlinkTick !== tickM) begin
      errors++;
      $display("FAIL model_tick edge=%0d got=%b exp=%b", edgeN, BlinkTick, tickM);
    end
    checks++;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    if (All !== 1'b0 || Blink !== 1'b0 || BlinkTick !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got=%b%b%b exp=000", All, Blink, BlinkTick);
    end
    checks++;
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b0);
      if (i == 5 || i == 10) begin
        if (BlinkTick !== 1'b1 || Blink !== (i == 5)) begin
          errors++;
          $display("FAIL reset_first_tick i=%0d got tick=%b blink=%b", i, BlinkTick, Blink);
        end
        checks++;
      end
    end
  endtask

  task automatic test_clean_press();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0);
      if (i == 2 + L) begin
        if (All !== 1'b0) begin
          errors++;
          $display("FAIL press_early got=%b exp=0", All);
        end
        checks++;
      end
      if (i == 3 + L) begin
        if (All !== 1'b1 || Blink !== 1'b1 || BlinkTick !== 1'b1) begin
          errors++;
          $display("FAIL press_toggle got=%b%b%b exp=111", All, Blink, BlinkTick);
        end
        checks++;
      end
      if (i == 8 + L) begin
        if (BlinkTick !== 1'b1 || Blink !== 1'b0) begin
          errors++;
          $display("FAIL press_next_toggle got tick=%b blink=%b exp tick=1 blink=0", BlinkTick, Blink);
        end
        checks++;
      end
    end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    if (All !== 1'b1) begin
      errors++;
      $display("FAIL release_keeps_all got=%b exp=1", All);
    end
    checks++;
  endtask

  task automatic test_bounce();
    bit pat[14] = '{1, 1, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 14; i++) begin
      step(pat[i], 1'b0);
      if (i == 6 + L) begin
        if (All !== 1'b1) begin
          errors++;
          $display("FAIL bounce_early got=%b exp=1", All);
        end
        checks++;
      end
      if (i == 7 + L) begin
        if (All !== 1'b0) begin
          errors++;
          $display("FAIL bounce_toggle got=%b exp=0", All);
        end
        checks++;
      end
    end
  endtask

  task automatic test_second_press();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    if (All !== 1'b1) begin
      errors++;
      $display("FAIL second_on got=%b exp=1", All);
    end
    checks++;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0);
    if (All !== 1'b0) begin
      errors++;
      $display("FAIL second_off got=%b exp=0", All);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3 + L; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    if (All !== 1'b0 || Blink !== 1'b0 || BlinkTick !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got=%b%b%b exp=000", All, Blink, BlinkTick);
    end
    checks++;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0);
      if (i == 2 + L) begin
        if (All !== 1'b0) begin
          errors++;
          $display("FAIL held_press_early got=%b exp=0", All);
        end
        checks++;
      end
      if (i == 3 + L) begin
        if (All !== 1'b1) begin
          errors++;
          $display("FAIL held_press_toggle got=%b exp=1", All);
        end
        checks++;
      end
    end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
  endtask

  task automatic test_random();
    int n = 0;
    while (n < 600) begin
      bit lvl = bit'($urandom_range(0, 1));
      int len = $urandom_range(1, 7);
      for (int j = 0; j < len; j++) begin
        step(lvl, $urandom_range(0, 99) == 0);
        n++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_second_press();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate3_driver.md
GATE3_DRIVER -- requirements
Module: gate3_driver

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, giving the consecutive stable samples needed to accept a button level change (integer >= 2).
REQ-002 The block SHALL have parameter BLINK_HALF_CYCLES, default 12500000, giving the clock cycles per Blink half-period (integer >= 2).
REQ-003 The block SHALL have port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port HazardButton, input, 1 bit: raw, bouncing, asynchronous push-button, high while pressed.
REQ-006 The block SHALL have port All, output, 1 bit: registered hazard-mode level fed to the downstream Gate3 All input.
REQ-007 The block SHALL have port Blink, output, 1 bit: registered square wave fed to the downstream Gate3 Blink input.
REQ-008 The block SHALL have port BlinkTick, output, 1 bit: one-cycle pulse asserted on every cycle in which Blink toggles.

Function
REQ-009 The debounce FSM SHALL have four states: RELEASED, PRESS_CHECK, PRESSED and RELEASE_CHECK.
REQ-010 From RELEASED, a high sample SHALL move the FSM to PRESS_CHECK with the stable counter set to 1.
REQ-011 In PRESS_CHECK, each high sample SHALL increment the counter; reaching DEBOUNCE_CYCLES SHALL move the FSM to PRESSED; any low sample SHALL return it to RELEASED and clear the counter.
REQ-012 PRESSED and RELEASE_CHECK SHALL mirror REQ-010 and REQ-011 with the levels inverted, returning to RELEASED after DEBOUNCE_CYCLES consecutive low samples.
REQ-013 All SHALL toggle on exactly the edge of the PRESS_CHECK to PRESSED transition, with 0 cycles of added latency after the DEBOUNCE_CYCLES-th high sample; releases SHALL never change All.
REQ-014 The blink counter SHALL run 0..BLINK_HALF_CYCLES-1; at terminal count it SHALL wrap to 0, toggle Blink and assert BlinkTick for that one cycle.
REQ-015 On the edge where All goes 0 to 1, the counter SHALL clear to 0, Blink SHALL be forced to 1 and BlinkTick SHALL be asserted, so the first flash is a full half-period.
REQ-016 If REQ-015 and terminal count coincide on the same edge, REQ-015 SHALL take priority, with a single BlinkTick and Blink = 1.
REQ-017 When All goes 1 to 0, Blink SHALL keep free-running with no phase change.
REQ-018 The counter width SHALL be $clog2(BLINK_HALF_CYCLES) and the debounce counter width $clog2(DEBOUNCE_CYCLES+1); neither counter SHALL overflow.

Reset
REQ-019 While Reset is high at a rising edge, the block SHALL set FSM = RELEASED, both counters = 0, All = 0, Blink = 0 and BlinkTick = 0.
REQ-020 Reset asserted mid-debounce or mid-half-period SHALL abandon the operation, with no All toggle and no BlinkTick on that edge.
REQ-021 After Reset deasserts, the first BlinkTick SHALL occur BLINK_HALF_CYCLES edges later.
REQ-022 A button already held when Reset deasserts SHALL be debounced as a new press and toggle All.

Configuration
REQ-023 When macro GATE3_DRIVER_SYNC_EN is defined, HazardButton SHALL pass through a two-flop synchronizer (reset to 0) before the FSM, adding exactly 2 cycles to the REQ-013 latency.
REQ-024 When GATE3_DRIVER_SYNC_EN is undefined, the FSM SHALL sample HazardButton directly, with no extra flops.

Verification (DEBOUNCE_CYCLES=4, BLINK_HALF_CYCLES=5, macro undefined unless stated)
REQ-025 Bench SHALL hold Reset for 2 edges and then release it -> All=0 and Blink=0, with the first BlinkTick and Blink=1 on the 5th edge after release and a toggle every 5 edges thereafter.
REQ-026 Bench SHALL hold HazardButton high for 10 cycles from edge k -> All=1 after edge k+3, Blink forced to 1 with counter cleared at that edge, and the next toggle at edge k+8.
REQ-027 Bench SHALL apply a bounce of 1,1,1,0,1,1,1,1 -> no toggle on the first run, and All toggles on the 4th high of the second run.
REQ-028 Bench SHALL apply a second clean press and release -> All returns to 0 with no Blink phase jump, and the release never toggles All.
REQ-029 Bench SHALL assert Reset during a PRESS_CHECK count of 3 -> All is unchanged at 0, the FSM is RELEASED, and the counters are 0.
REQ-030 Bench SHALL repeat REQ-026 with GATE3_DRIVER_SYNC_EN defined -> All toggles after edge k+5.
